// File: rtl/ssm_pkg.sv
// -----------------------------------------------------------------------------
// ssm_pkg
// Shared definitions for the SSM datapath blocks.
//   DW            : FP16 element width
//   FP16_ZERO     : FP16 +0, used to pad unwritten lanes
//   tpg()         : tiles per group for a given group/tile lane count
//   bank_state_t  : life cycle of one collector bank
// -----------------------------------------------------------------------------
package ssm_pkg;

  localparam int DW = 16;
  localparam logic [15:0] FP16_ZERO = 16'h0000;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  function automatic int tpg(input int n_total, input int n_tile);
    return n_total / n_tile;
  endfunction

endpackage

// File: rtl/ssm_sync_fifo.sv
// -----------------------------------------------------------------------------
// ssm_sync_fifo
// Single-clock FIFO with a registered occupancy count.
// Ports:
//   clk, rst          : clock, synchronous active-high reset (empties FIFO)
//   push_i, wdata_i   : write request and data (ignored when full)
//   pop_i             : read request (ignored when empty)
//   rdata_o           : head entry, valid while !empty_o
//   full_o, empty_o   : flags decoded from the registered count only, so a
//                       pop in the same cycle never frees room for a push
// -----------------------------------------------------------------------------
module ssm_sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  if (DEPTH < 2) begin : g_depth_check
    $error("ssm_sync_fifo: DEPTH must be at least 2");
  end

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push_i && !full_o;
    pop_ok   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the pointers/count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ssm_group_reducer.sv
// -----------------------------------------------------------------------------
// ssm_group_reducer
// Collects N_TILE-lane hC tiles into N_TOTAL-lane groups using two ping-pong
// banks and pairs each finished group with its x*D scalar from a FIFO.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   tile_valid_i / tile_ready_o   : tile handshake; tile_last_i closes early
//   hC_tile_i                     : tile lanes, lane 0 in LSBs
//   xd_valid_i / xd_ready_o, xd_i : x*D scalar handshake (one per group)
//   grp_valid_o / grp_ready_i     : group handshake toward the adder tree
//   grp_bus_o                     : slot k = tile k, unwritten slots are +0
//   grp_xd_o, grp_ntiles_o        : paired x*D and tiles actually written
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid must not depend on ready, and while valid is high without
// ready the presented payload holds stable.
// -----------------------------------------------------------------------------
module ssm_group_reducer import ssm_pkg::*; #(
  parameter int DW            = ssm_pkg::DW,
  parameter int N_TILE        = 16,
  parameter int N_TOTAL       = 128,
  parameter int XD_FIFO_DEPTH = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        tile_valid_i,
  output logic                                        tile_ready_o,
  input  logic                                        tile_last_i,
  input  logic [N_TILE*DW-1:0]                        hC_tile_i,
  input  logic                                        xd_valid_i,
  output logic                                        xd_ready_o,
  input  logic [DW-1:0]                               xd_i,
  output logic                                        grp_valid_o,
  input  logic                                        grp_ready_i,
  output logic [N_TOTAL*DW-1:0]                       grp_bus_o,
  output logic [DW-1:0]                               grp_xd_o,
  output logic [$clog2(tpg(N_TOTAL, N_TILE)+1)-1:0]   grp_ntiles_o
);

  localparam int TPG = tpg(N_TOTAL, N_TILE);
  localparam int TW  = N_TILE * DW;
  localparam int PTW = (TPG > 1) ? $clog2(TPG) : 1;
  localparam int NTW = $clog2(TPG + 1);

  if ((N_TOTAL % N_TILE) != 0 || TPG < 2) begin : g_tpg_check
    $error("ssm_group_reducer: N_TOTAL/N_TILE must be an integer >= 2");
  end

  // Bank control state (visible to checkers as state_q / wr_bank_q / rd_bank_q)
  bank_state_t    state_q  [2];
  bank_state_t    state_d  [2];
  logic [TPG-1:0] mask_q   [2];
  logic [TPG-1:0] mask_d   [2];
  logic [NTW-1:0] ntiles_q [2];
  logic [NTW-1:0] ntiles_d [2];
  logic [PTW-1:0] tile_ptr_q, tile_ptr_d;
  logic           wr_bank_q, wr_bank_d;
  logic           rd_bank_q, rd_bank_d;
  logic [TW-1:0]  slot_q [2][TPG];

  logic           tile_acc, tile_close, grp_fire;
  logic           fifo_full, fifo_empty;
  logic [DW-1:0]  fifo_rdata;

  // Outputs are forced to their idle values while rst is high, even before
  // the reset edge has cleared the registers.
  assign tile_ready_o = rst || (state_q[wr_bank_q] != FULL);
  assign xd_ready_o   = rst || !fifo_full;
  assign grp_valid_o  = !rst && (state_q[rd_bank_q] == FULL) && !fifo_empty;
  assign grp_xd_o     = (!rst && !fifo_empty) ? fifo_rdata : '0;
  assign grp_ntiles_o = rst ? '0 : ntiles_q[rd_bank_q];

  assign tile_acc   = !rst && tile_valid_i && tile_ready_o;
  assign tile_close = tile_acc && (tile_last_i || (tile_ptr_q == PTW'(TPG - 1)));
  assign grp_fire   = grp_valid_o && grp_ready_i;

  // Slots never written in this group read as FP16 +0 (mask gates stale data).
  for (genvar k = 0; k < TPG; k++) begin : g_slot
    assign grp_bus_o[k*TW +: TW] = (!rst && mask_q[rd_bank_q][k]) ?
                                   slot_q[rd_bank_q][k] : {N_TILE{DW'(FP16_ZERO)}};
  end

  // The drained bank is FULL and the filled bank is not, so the two updates
  // below never touch the same bank in one cycle.
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    ntiles_d   = ntiles_q;
    tile_ptr_d = tile_ptr_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    if (grp_fire) begin
      state_d[rd_bank_q]  = EMPTY;
      mask_d[rd_bank_q]   = '0;
      ntiles_d[rd_bank_q] = '0;
      rd_bank_d           = ~rd_bank_q;
    end
    if (tile_acc) begin
      mask_d[wr_bank_q][tile_ptr_q] = 1'b1;
      if (tile_close) begin
        state_d[wr_bank_q]  = FULL;
        ntiles_d[wr_bank_q] = NTW'(tile_ptr_q) + NTW'(1);
        tile_ptr_d          = '0;
        wr_bank_d           = ~wr_bank_q;
      end else begin
        state_d[wr_bank_q]  = FILLING;
        tile_ptr_d          = tile_ptr_q + PTW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        state_q[b]  <= EMPTY;
        mask_q[b]   <= '0;
        ntiles_q[b] <= '0;
      end
      tile_ptr_q <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      ntiles_q   <= ntiles_d;
      tile_ptr_q <= tile_ptr_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tile_acc) slot_q[wr_bank_q][tile_ptr_q] <= hC_tile_i;
  end

  ssm_sync_fifo #(
    .W     (DW),
    .DEPTH (XD_FIFO_DEPTH)
  ) u_xd_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (xd_valid_i),
    .wdata_i (xd_i),
    .pop_i   (grp_fire),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_ssm_group_reducer.sv
module tb_ssm_group_reducer;

  localparam int DW      = 16;
  localparam int N_TILE  = 16;
  localparam int N_TOTAL = 128;
  localparam int TPG     = 8;
  localparam int DEPTH   = 4;
  localparam int TW      = N_TILE * DW;
  localparam int BW      = N_TOTAL * DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          tile_valid = 1'b0;
  logic          tile_ready;
  logic          tile_last = 1'b0;
  logic [TW-1:0] hc_tile = '0;
  logic          xd_valid = 1'b0;
  logic          xd_ready;
  logic [DW-1:0] xd = '0;
  logic          grp_valid;
  logic          grp_ready = 1'b0;
  logic [BW-1:0] grp_bus;
  logic [DW-1:0] grp_xd;
  logic [3:0]    grp_ntiles;

  ssm_group_reducer #(
    .DW(DW), .N_TILE(N_TILE), .N_TOTAL(N_TOTAL), .XD_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tile_valid_i (tile_valid),
    .tile_ready_o (tile_ready),
    .tile_last_i  (tile_last),
    .hC_tile_i    (hc_tile),
    .xd_valid_i   (xd_valid),
    .xd_ready_o   (xd_ready),
    .xd_i         (xd),
    .grp_valid_o  (grp_valid),
    .grp_ready_i  (grp_ready),
    .grp_bus_o    (grp_bus),
    .grp_xd_o     (grp_xd),
    .grp_ntiles_o (grp_ntiles)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];   // xD scoreboard, in push order

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [TW-1:0] fill(input logic [DW-1:0] v);
    return {N_TILE{v}};
  endfunction

  function automatic logic [BW-1:0] make_bus(input int n, input logic [DW-1:0] base);
    logic [BW-1:0] b;
    b = '0;
    for (int k = 0; k < n; k++) b[k*TW +: TW] = fill(base + DW'(k));
    return b;
  endfunction

  function automatic int diff_slot(input logic [BW-1:0] a, input logic [BW-1:0] b);
    for (int k = 0; k < TPG; k++) if (a[k*TW +: TW] !== b[k*TW +: TW]) return k;
    return 0;
  endfunction

  // ---------------- drivers ----------------
  task automatic reset_dut();
    rst = 1'b1; tile_valid = 1'b0; tile_last = 1'b0; xd_valid = 1'b0; grp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic send_tile(input logic [DW-1:0] v, input logic last);
    bit ok;
    ok = 1'b0;
    tile_valid = 1'b1; tile_last = last; hc_tile = fill(v);
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (tile_ready) ok = 1'b1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL tile_accept_timeout got ready=0 want ready=1 (tile %h)", v);
    end else begin
      @(posedge clk); #1;
    end
    tile_valid = 1'b0; tile_last = 1'b0;
  endtask

  task automatic push_xd(input logic [DW-1:0] v);
    bit ok;
    ok = 1'b0;
    xd_valid = 1'b1; xd = v;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (xd_ready) ok = 1'b1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL xd_accept_timeout got ready=0 want ready=1 (xd %h)", v);
    end else begin
      exp_q.push_back(v);
      @(posedge clk); #1;
    end
    xd_valid = 1'b0;
  endtask

  task automatic send_group(input int n, input logic [DW-1:0] base);
    for (int k = 0; k < n; k++) send_tile(base + DW'(k), k == n - 1);
  endtask

  // One-cycle grp_ready pulse; checks the group is presented with the
  // scoreboard's oldest xD.
  task automatic drain(input string name);
    logic [DW-1:0] want;
    grp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (grp_valid !== 1'b1) begin
      errors++; $display("FAIL %s_drain_valid got %b want 1", name, grp_valid);
    end
    want = (exp_q.size() > 0) ? exp_q[0] : 'x;
    checks++;
    if (grp_xd !== want) begin
      errors++; $display("FAIL %s_drain_xd got %h want %h", name, grp_xd, want);
    end
    @(posedge clk); #1;
    grp_ready = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (tile_ready !== 1'b1) begin errors++; $display("FAIL reset_tile_ready got %b want 1", tile_ready); end
    checks++; if (xd_ready !== 1'b1) begin errors++; $display("FAIL reset_xd_ready got %b want 1", xd_ready); end
    checks++; if (grp_valid !== 1'b0) begin errors++; $display("FAIL reset_grp_valid got %b want 0", grp_valid); end
    checks++; if (grp_bus !== '0) begin errors++; $display("FAIL reset_grp_bus got slot0 %h want 0", grp_bus[TW-1:0]); end
    checks++; if (grp_xd !== '0) begin errors++; $display("FAIL reset_grp_xd got %h want 0", grp_xd); end
    checks++; if (grp_ntiles !== 4'd0) begin errors++; $display("FAIL reset_ntiles got %0d want 0", grp_ntiles); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (tile_ready !== 1'b1) begin errors++; $display("FAIL post_reset_tile_ready got %b want 1", tile_ready); end
    checks++; if (grp_valid !== 1'b0) begin errors++; $display("FAIL post_reset_grp_valid got %b want 0", grp_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [BW-1:0] want;
    push_xd(16'h4000);
    for (int k = 0; k < TPG; k++) begin
      send_tile(16'h3C00 + DW'(k), 1'b0);
      if (k == TPG - 2) begin
        #1;
        checks++; if (grp_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", grp_valid); end
      end
    end
    @(negedge clk);
    want = make_bus(8, 16'h3C00);
    checks++; if (grp_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", grp_valid); end
    checks++;
    if (grp_bus !== want) begin
      errors++;
      $display("FAIL basic_bus slot %0d got %h want %h", diff_slot(grp_bus, want),
               grp_bus[diff_slot(grp_bus, want)*TW +: TW], want[diff_slot(grp_bus, want)*TW +: TW]);
    end
    checks++; if (grp_xd !== 16'h4000) begin errors++; $display("FAIL basic_xd got %h want 4000", grp_xd); end
    checks++; if (grp_ntiles !== 4'd8) begin errors++; $display("FAIL basic_ntiles got %0d want 8", grp_ntiles); end
    @(posedge clk); #1;
    drain("basic");
    @(negedge clk);
    checks++; if (grp_valid !== 1'b0) begin errors++; $display("FAIL basic_after_drain_valid got %b want 0", grp_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int acc, idx, bad_ready, bad_bus;
    logic [BW-1:0] want0, want1;
    acc = 0; idx = 0; bad_ready = 0; bad_bus = 0;
    want0 = make_bus(8, 16'h1000);
    want1 = make_bus(8, 16'h1008);
    grp_ready = 1'b0;
    push_xd(16'h4101);
    push_xd(16'h4102);
    push_xd(16'h4103);
    tile_valid = 1'b1; tile_last = 1'b0;
    for (int c = 0; c < 24; c++) begin
      hc_tile = fill(16'h1000 + DW'(idx));
      @(negedge clk);
      if (acc >= 16) begin
        if (tile_ready !== 1'b0) bad_ready++;
        if (grp_bus !== want0) bad_bus++;
      end
      if (tile_ready) begin acc++; idx++; end
      @(posedge clk); #1;
    end
    tile_valid = 1'b0;
    checks++; if (acc != 16) begin errors++; $display("FAIL bp_accept_count got %0d want 16", acc); end
    checks++; if (bad_ready != 0) begin errors++; $display("FAIL bp_ready_low got %0d high cycles want 0", bad_ready); end
    checks++; if (bad_bus != 0) begin errors++; $display("FAIL bp_bus_stable got %0d changed cycles want 0", bad_bus); end
    drain("bp_group0");
    @(negedge clk);
    checks++; if (tile_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_release got %b want 1", tile_ready); end
    checks++; if (grp_valid !== 1'b1) begin errors++; $display("FAIL bp_group1_valid got %b want 1", grp_valid); end
    checks++;
    if (grp_bus !== want1) begin
      errors++;
      $display("FAIL bp_group1_bus slot %0d got %h want %h", diff_slot(grp_bus, want1),
               grp_bus[diff_slot(grp_bus, want1)*TW +: TW], want1[diff_slot(grp_bus, want1)*TW +: TW]);
    end
    checks++; if (grp_xd !== 16'h4102) begin errors++; $display("FAIL bp_group1_xd got %h want 4102", grp_xd); end
    @(posedge clk); #1;
    reset_dut();
  endtask

  task automatic test_partial();
    logic [BW-1:0] want;
    push_xd(16'h5000);
    send_group(3, 16'h2000);
    @(negedge clk);
    want = make_bus(3, 16'h2000);
    checks++; if (grp_ntiles !== 4'd3) begin errors++; $display("FAIL partial_ntiles got %0d want 3", grp_ntiles); end
    checks++;
    if (grp_bus !== want) begin
      errors++;
      $display("FAIL partial_bus slot %0d got %h want %h", diff_slot(grp_bus, want),
               grp_bus[diff_slot(grp_bus, want)*TW +: TW], want[diff_slot(grp_bus, want)*TW +: TW]);
    end
    @(posedge clk); #1;
    drain("partial");
    push_xd(16'h5001);
    send_group(8, 16'h2100);
    @(negedge clk);
    want = make_bus(8, 16'h2100);
    checks++; if (grp_ntiles !== 4'd8) begin errors++; $display("FAIL full_after_partial_ntiles got %0d want 8", grp_ntiles); end
    checks++; if (grp_bus !== want) begin errors++; $display("FAIL full_after_partial_bus slot %0d mismatch got %h", diff_slot(grp_bus, want), grp_bus[diff_slot(grp_bus, want)*TW +: TW]); end
    @(posedge clk); #1;
    drain("full_after_partial");
    // Refill the first bank with fewer tiles: its old slot 2 must read +0.
    push_xd(16'h5002);
    send_group(2, 16'h2200);
    @(negedge clk);
    want = make_bus(2, 16'h2200);
    checks++; if (grp_ntiles !== 4'd2) begin errors++; $display("FAIL reuse_ntiles got %0d want 2", grp_ntiles); end
    checks++; if (grp_bus !== want) begin errors++; $display("FAIL reuse_bus slot %0d got %h want %h", diff_slot(grp_bus, want), grp_bus[diff_slot(grp_bus, want)*TW +: TW], want[diff_slot(grp_bus, want)*TW +: TW]); end
    @(posedge clk); #1;
    drain("reuse");
  endtask

  task automatic test_late_xd();
    int bad;
    bad = 0;
    reset_dut();
    send_group(8, 16'h3000);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (grp_valid !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL late_xd_hold got %0d valid cycles want 0", bad); end
    push_xd(16'h6000);
    @(negedge clk);
    checks++; if (grp_valid !== 1'b1) begin errors++; $display("FAIL late_xd_valid got %b want 1", grp_valid); end
    checks++; if (grp_xd !== 16'h6000) begin errors++; $display("FAIL late_xd_value got %h want 6000", grp_xd); end
    @(posedge clk); #1;
    drain("late_xd");
  endtask

  task automatic test_fifo_full();
    int acc;
    acc = 0;
    reset_dut();
    xd_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      xd = 16'h7000 + DW'(i);
      @(negedge clk);
      if (xd_ready) begin acc++; exp_q.push_back(xd); end
      @(posedge clk); #1;
    end
    xd = 16'h7010;
    @(negedge clk);
    checks++; if (acc != 4) begin errors++; $display("FAIL fifo_accept_count got %0d want 4", acc); end
    checks++; if (xd_ready !== 1'b0) begin errors++; $display("FAIL fifo_full_ready got %b want 0", xd_ready); end
    @(posedge clk); #1;
    send_group(8, 16'h5000);
    grp_ready = 1'b1;
    @(negedge clk);
    checks++; if (grp_valid !== 1'b1) begin errors++; $display("FAIL fifo_pop_valid got %b want 1", grp_valid); end
    checks++; if (xd_ready !== 1'b0) begin errors++; $display("FAIL fifo_no_passthrough got %b want 0", xd_ready); end
    checks++; if (grp_xd !== 16'h7000) begin errors++; $display("FAIL fifo_pop_xd got %h want 7000", grp_xd); end
    @(posedge clk); #1;
    grp_ready = 1'b0;
    void'(exp_q.pop_front());
    @(negedge clk);
    checks++; if (xd_ready !== 1'b1) begin errors++; $display("FAIL fifo_after_pop_ready got %b want 1", xd_ready); end
    if (xd_ready) exp_q.push_back(16'h7010);
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (xd_ready !== 1'b0) begin errors++; $display("FAIL fifo_refull_ready got %b want 0", xd_ready); end
    xd_valid = 1'b0;
    @(posedge clk); #1;
    send_group(8, 16'h5100);
    drain("fifo_next");
  endtask

  task automatic test_reset_mid_fill();
    int bad;
    logic [BW-1:0] want;
    bad = 0;
    reset_dut();
    push_xd(16'h8000);
    for (int k = 0; k < 5; k++) send_tile(16'h4400 + DW'(k), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (tile_ready !== 1'b1) begin errors++; $display("FAIL midrst_tile_ready got %b want 1", tile_ready); end
    checks++; if (xd_ready !== 1'b1) begin errors++; $display("FAIL midrst_xd_ready got %b want 1", xd_ready); end
    checks++; if (grp_valid !== 1'b0) begin errors++; $display("FAIL midrst_grp_valid got %b want 0", grp_valid); end
    checks++; if (grp_bus !== '0) begin errors++; $display("FAIL midrst_grp_bus got slot0 %h want 0", grp_bus[TW-1:0]); end
    checks++; if (grp_xd !== '0) begin errors++; $display("FAIL midrst_grp_xd got %h want 0", grp_xd); end
    checks++; if (grp_ntiles !== 4'd0) begin errors++; $display("FAIL midrst_ntiles got %0d want 0", grp_ntiles); end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    send_group(8, 16'h4500);
    push_xd(16'h8800);
    @(negedge clk);
    want = make_bus(8, 16'h4500);
    checks++; if (grp_ntiles !== 4'd8) begin errors++; $display("FAIL midrst_fresh_ntiles got %0d want 8", grp_ntiles); end
    checks++; if (grp_bus !== want) begin errors++; $display("FAIL midrst_fresh_bus slot %0d got %h want %h", diff_slot(grp_bus, want), grp_bus[diff_slot(grp_bus, want)*TW +: TW], want[diff_slot(grp_bus, want)*TW +: TW]); end
    @(posedge clk); #1;
    drain("midrst");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (grp_valid !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL midrst_single_group got %0d extra valid cycles want 0", bad); end
    @(posedge clk); #1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_partial();
    test_late_xd();
    test_fifo_full();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssm_group_reducer.md
# ssm_group_reducer

Collects streamed `hC` tiles (N_TILE FP16 lanes each) into full N_TOTAL-lane groups and pairs each group with its `x*D` scalar. It is the next generation of the SSM tile collector that sits between the `hC` multiplier stage and the 128-input adder tree / `y_out` adder.

- Ping-pong group banks remove input stalls during drain.
- A per-group xD FIFO replaces the fixed-delay xD alignment.
- Full valid/ready backpressure on input and output.
- Partial (short) groups supported via `tile_last_i`, with zero padding.

## Interface

Parameters:
- `DW`, 16, element width (FP16).
- `N_TILE`, 16, lanes per input tile.
- `N_TOTAL`, 128, lanes per group; `N_TOTAL/N_TILE` (TPG) must be an integer ≥2, otherwise elaboration fails.
- `XD_FIFO_DEPTH`, 4, xD FIFO entries (≥2).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tile_valid_i`  in  1  tile present.
- `tile_ready_o`  out  1  tile accepted when high with valid.
- `tile_last_i`  in  1  this tile closes the group early.
- `hC_tile_i`  in  N_TILE*DW  tile lanes, lane 0 in LSBs.
- `xd_valid_i`  in  1  xD scalar present.
- `xd_ready_o`  out  1  xD FIFO not full.
- `xd_i`  in  DW  x*D for one group, in group order.
- `grp_valid_o`  out  1  group + xD available.
- `grp_ready_i`  in  1  downstream takes group.
- `grp_bus_o`  out  N_TOTAL*DW  slot k = tile k of group.
- `grp_xd_o`  out  DW  xD paired with group.
- `grp_ntiles_o`  out  clog2(TPG+1)  tiles actually written (1..TPG).

## Operation

Banks and states:
- Two banks, 0 and 1. Each holds TPG slots, a per-slot written mask, an `ntiles` count, and a state EMPTY / FILLING / FULL.
- `wr_bank` selects the bank being filled; `rd_bank` selects the bank being drained. Both start at 0.

Input side:
- `tile_ready_o` = (state[wr_bank] != FULL).
- On accept: write slot `tile_ptr`, set its mask bit, bank goes to FILLING.
- Group closes when `tile_ptr == TPG-1` or `tile_last_i` is high on the accepted tile. On close:
  - bank goes to FULL and `ntiles` = `tile_ptr+1`;
  - `tile_ptr` returns to 0 and `wr_bank` toggles.
- `tile_last_i` on slot 0 gives a one-tile group.

xD FIFO:
- Push on `xd_valid_i && xd_ready_o`.
- `xd_ready_o` = !full, taken from the registered count only; there is no pass-through when full, even if a pop happens in the same cycle.

Output side:
- `grp_valid_o` = (state[rd_bank] == FULL) && FIFO non-empty.
- Slots with a cleared mask bit output 16'h0000 (FP16 +0).
- On `grp_valid_o && grp_ready_i`: pop the FIFO, set the bank to EMPTY, clear its mask, toggle `rd_bank`.
- While `grp_valid_o && !grp_ready_i`: all `grp_*` outputs hold stable.

Simultaneous events:
- Closing one bank and draining the other in the same cycle is legal.
- A tile accepted into a bank in the same cycle that bank is drained cannot occur, because `tile_ready_o` is low on a FULL `wr_bank`.

## Timing

Latency:
- The tile that closes a group is accepted at edge t; `grp_valid_o` rises after edge t (visible in cycle t+1) if the FIFO already holds an entry.
- xD pushed at edge t makes an already-FULL group valid in cycle t+1.

Backpressure release:
- When both banks are FULL, `tile_ready_o` is low. It returns high in the cycle after the output handshake edge.

Throughput:
- One tile per cycle sustained when `grp_ready_i` is high at least once every TPG cycles.

Reset (`rst` high at an edge), applied mid-operation as well:
- Both banks EMPTY, masks cleared, pointers and banks at 0, FIFO emptied. Partial group contents are discarded.
- Output values during reset: `tile_ready_o`=1, `xd_ready_o`=1, `grp_valid_o`=0, `grp_bus_o`=0, `grp_xd_o`=0, `grp_ntiles_o`=0.

## Structure

- Package `ssm_pkg` holds: `DW`, `FP16_ZERO`, the TPG derivation function, and the `bank_state_t` enum (EMPTY, FILLING, FULL). Other SSM blocks reuse it.
- Sub-module `ssm_sync_fifo` implements the xD FIFO: parametrised W/DEPTH, registered count, full/empty flags, synchronous active-high reset.
- Bank storage lives in this module as plain registers, with slot-select write enables.

## Test plan

- Basic group:
  - Stimulus: push xD 16'h4000, then 8 back-to-back tiles, all lanes of tile k = 16'h3C00+k.
  - Required response: one cycle after the 8th accept, `grp_valid_o`=1; slot k lanes = 3C00+k; `grp_xd_o`=4000; `grp_ntiles_o`=8.
- Backpressure:
  - Stimulus: `grp_ready_i`=0, 3 xD pushed, 24 tiles offered.
  - Required response: exactly 16 tiles accepted; `tile_ready_o`=0 from the cycle after the 16th accept; bus stable.
  - Then pulse `grp_ready_i` for one cycle: group 0 leaves, `tile_ready_o`=1 next cycle, group 1 presented next.
- Partial group:
  - Stimulus: 3 tiles, `tile_last_i` on the 3rd.
  - Required response: `grp_ntiles_o`=3, slots 3..7 all 16'h0000.
  - A following full group of 8 shows no residue from the partial group.
- Late xD:
  - Stimulus: group completes with the FIFO empty.
  - Required response: `grp_valid_o` stays 0 for 20 cycles; xD pushed at edge T gives `grp_valid_o`=1 in cycle T+1 with that xD.
- FIFO full:
  - Stimulus: DEPTH=4, `xd_valid_i` held high for 6 cycles with no drain.
  - Required response: 4 accepted, `xd_ready_o`=0 after the 4th; one pop lets exactly one more push through.
- Reset mid-fill:
  - Stimulus: 5 tiles, then `rst` for 1 cycle, then 8 fresh tiles plus 1 xD.
  - Required response: all outputs at reset values during reset; the single emitted group contains only the fresh tiles, `grp_ntiles_o`=8.
